// File: rtl/data_write_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_write_buffer
//
// Posted-write buffer between the data cache memory-side port and a single-port
// block RAM (BM). Cache writes are pushed into a small FIFO and drained to BM
// whenever the port is not needed by a read miss. Reads that hit a pending
// write are forwarded from the FIFO (youngest matching entry); all other reads
// go to BM. Every accepted request completes with a one-cycle data_ok pulse.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cache_data_req      - request valid
//   cache_data_wr       - 1 = write, 0 = read
//   cache_data_addr     - word address
//   cache_data_wdata    - write data
//   cache_data_addr_ok  - request accepted this cycle (combinational)
//   cache_data_data_ok  - one-cycle completion pulse
//   cache_data_rdata    - read data, holds its last value between reads
//   bram_ena/wea        - BM enable / write enable
//   bram_addr/din       - BM address / write data
//   bram_dout           - BM read data, valid one cycle after a read enable
//   wb_empty            - FIFO holds no entries
// -----------------------------------------------------------------------------
module data_write_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_data_req,
    input  logic                  cache_data_wr,
    input  logic [ADDR_WIDTH-1:0] cache_data_addr,
    input  logic [DATA_WIDTH-1:0] cache_data_wdata,
    output logic                  cache_data_addr_ok,
    output logic                  cache_data_data_ok,
    output logic [DATA_WIDTH-1:0] cache_data_rdata,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  wb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // FIFO storage and bookkeeping
    logic [ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    // Response tracking
    logic                  r_data_ok;
    logic                  r_rd_pend;
    logic                  r_rd_fwd;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic [DATA_WIDTH-1:0] r_rdata_hold;

    // Combinational control
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_rd_hit;
    logic                  w_rd_miss;
    logic                  w_drain;

    // Search valid entries oldest to youngest so the youngest match wins.
    always_comb begin : hit_search
        logic [PTR_W-1:0] v_idx;
        v_idx      = {PTR_W{1'b0}};
        w_hit      = 1'b0;
        w_hit_data = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_fifo_addr[v_idx] == cache_data_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_fifo_data[v_idx];
            end else begin
                w_hit      = w_hit;
            end
        end
    end

    // Acceptance, read hit/miss classification and drain decision.
    always_comb begin
        w_addr_ok = 1'b0;
        if (rst) begin
            w_addr_ok = 1'b0;
        end else if (cache_data_wr) begin
            // A full FIFO refuses writes even if it drains this cycle.
            w_addr_ok = (r_count != FULL_CNT);
        end else begin
            w_addr_ok = 1'b1;
        end
        w_accept  = cache_data_req & w_addr_ok;
        w_push    = w_accept & cache_data_wr;
        w_rd_hit  = w_accept & ~cache_data_wr & w_hit;
        w_rd_miss = w_accept & ~cache_data_wr & ~w_hit;
        // A read miss owns the BM port; draining waits for a free cycle.
        w_drain   = ~rst & ~w_rd_miss & (r_count != {CNT_W{1'b0}});
    end

    // BM port multiplexer: read miss, else drain of the head entry, else idle.
    always_comb begin
        bram_ena  = 1'b0;
        bram_wea  = 1'b0;
        bram_addr = {ADDR_WIDTH{1'b0}};
        bram_din  = {DATA_WIDTH{1'b0}};
        if (w_rd_miss) begin
            bram_ena  = 1'b1;
            bram_addr = cache_data_addr;
        end else if (w_drain) begin
            bram_ena  = 1'b1;
            bram_wea  = 1'b1;
            bram_addr = r_fifo_addr[r_head];
            bram_din  = r_fifo_data[r_head];
        end else begin
            bram_ena  = 1'b0;
        end
    end

    // FIFO entry storage; validity is tracked by head/count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_tail] <= cache_data_addr;
            r_fifo_data[r_tail] <= cache_data_wdata;
        end
    end

    // Pointers, occupancy and response state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= {PTR_W{1'b0}};
            r_tail       <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_data_ok    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_fwd     <= 1'b0;
            r_fwd_data   <= {DATA_WIDTH{1'b0}};
            r_rdata_hold <= {DATA_WIDTH{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_data_ok <= w_accept;
            r_rd_pend <= w_rd_miss;
            r_rd_fwd  <= w_rd_hit;
            if (w_rd_hit) begin
                r_fwd_data <= w_hit_data;
            end
            // Remember the value just returned so rdata holds between reads.
            if (r_rd_pend) begin
                r_rdata_hold <= bram_dout;
            end else if (r_rd_fwd) begin
                r_rdata_hold <= r_fwd_data;
            end
        end
    end

    // Read data: BM output for a miss, forward register for a hit, else hold.
    always_comb begin
        cache_data_rdata = r_rdata_hold;
        if (r_rd_pend) begin
            cache_data_rdata = bram_dout;
        end else if (r_rd_fwd) begin
            cache_data_rdata = r_fwd_data;
        end else begin
            cache_data_rdata = r_rdata_hold;
        end
    end

    assign cache_data_addr_ok = w_addr_ok;
    assign cache_data_data_ok = r_data_ok;
    assign wb_empty           = (r_count == {CNT_W{1'b0}});

endmodule

// File: tb/tb_data_write_buffer.sv
`timescale 1ns/1ps
// Self-checking bench for data_write_buffer: directed vector table, a few
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_data_write_buffer;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int NWORD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          addr_ok, data_ok;
    logic [DW-1:0] rdata;
    logic          bram_ena, bram_wea;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout = 32'h0;
    logic          wb_empty;

    always #5 clk = ~clk;

    data_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cache_data_req(req), .cache_data_wr(wr),
        .cache_data_addr(addr), .cache_data_wdata(wdata),
        .cache_data_addr_ok(addr_ok), .cache_data_data_ok(data_ok),
        .cache_data_rdata(rdata),
        .bram_ena(bram_ena), .bram_wea(bram_wea),
        .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .wb_empty(wb_empty)
    );

    // Single-port block RAM with one-cycle read latency
    logic [DW-1:0] bm_mem [NWORD];
    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) bm_mem[bram_addr] <= bram_din;
            else          bram_dout <= bm_mem[bram_addr];
        end
    end

    // Reference model: pending writes in program order, the logical memory a
    // read must observe, and the image BM should hold after draining.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t          pq[$];
    logic [DW-1:0] ref_mem [NWORD];
    logic [DW-1:0] bm_ref  [NWORD];
    logic          exp_dok   = 1'b0;
    logic          exp_rd    = 1'b0;
    logic [DW-1:0] exp_rdata = 32'h0;
    logic [DW-1:0] last_rdata = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          req, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          e_ok, e_ena, e_wea;
        logic [AW-1:0] e_baddr;
        logic [DW-1:0] e_din;
        logic          e_dok;
        logic [DW-1:0] e_rdata;
        logic          e_empty;
    } vec_t;

    vec_t tbl [14];
    vec_t nullv;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: drive at posedge+1, compare at negedge, advance model.
    task automatic cyc(input logic i_req, input logic i_wr, input logic [AW-1:0] i_addr,
                       input logic [DW-1:0] i_wdata, input bit use_tbl, input vec_t tv);
        logic m_ok, m_acc, m_hit, m_miss, m_drain;
        logic [AW-1:0] m_baddr;
        logic [DW-1:0] m_din;
        ent_t h;
        req = i_req; wr = i_wr; addr = i_addr; wdata = i_wdata;
        m_ok  = i_wr ? (pq.size() != DEPTH) : 1'b1;
        m_acc = i_req && m_ok;
        m_hit = 1'b0;
        foreach (pq[i]) if (pq[i].a == i_addr) m_hit = 1'b1;
        m_miss  = m_acc && !i_wr && !m_hit;
        m_drain = !m_miss && (pq.size() != 0);
        m_baddr = 10'h0;
        m_din   = 32'h0;
        if (m_miss) begin
            m_baddr = i_addr;
        end else if (m_drain) begin
            m_baddr = pq[0].a;
            m_din   = pq[0].d;
        end
        @(negedge clk);
        if (use_tbl) begin
            if (i_req) chk("tbl_addr_ok", 32'(addr_ok), 32'(tv.e_ok));
            chk("tbl_bram_ena", 32'(bram_ena), 32'(tv.e_ena));
            chk("tbl_bram_wea", 32'(bram_wea), 32'(tv.e_wea));
            chk("tbl_bram_addr", 32'(bram_addr), 32'(tv.e_baddr));
            chk("tbl_bram_din", bram_din, tv.e_din);
            chk("tbl_data_ok", 32'(data_ok), 32'(tv.e_dok));
            chk("tbl_rdata", rdata, tv.e_rdata);
            chk("tbl_wb_empty", 32'(wb_empty), 32'(tv.e_empty));
        end else begin
            if (i_req) chk("addr_ok", 32'(addr_ok), 32'(m_ok));
            chk("bram_ena", 32'(bram_ena), 32'(m_miss || m_drain));
            chk("bram_wea", 32'(bram_wea), 32'(m_drain));
            chk("bram_addr", 32'(bram_addr), 32'(m_baddr));
            chk("bram_din", bram_din, m_din);
            chk("data_ok", 32'(data_ok), 32'(exp_dok));
            chk("rdata", rdata, exp_rd ? exp_rdata : last_rdata);
            chk("wb_empty", 32'(wb_empty), 32'(pq.size() == 0));
        end
        if (exp_rd) last_rdata = exp_rdata;
        if (m_drain) begin
            h = pq.pop_front();
            bm_ref[h.a] = h.d;
        end
        if (m_acc && i_wr) begin
            pq.push_back('{a: i_addr, d: i_wdata});
            ref_mem[i_addr] = i_wdata;
        end
        exp_rd  = m_acc && !i_wr;
        if (exp_rd) exp_rdata = ref_mem[i_addr];
        exp_dok = m_acc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, nullv);
    endtask

    initial begin
        int mism;
        int r;
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 10'h0; wdata = 32'h0;
        for (int i = 0; i < NWORD; i++) begin
            bm_mem[i]  = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
            bm_ref[i]  = 32'hA500_0000 | 32'(i);
        end
        bm_mem[10'h100]  = 32'h1234_5678;
        ref_mem[10'h100] = 32'h1234_5678;
        bm_ref[10'h100]  = 32'h1234_5678;

        //            req   wr    addr     wdata         ok    ena   wea   baddr    din           dok   rdata         empty
        tbl[0]  = '{1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[1]  = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[3]  = '{1'b1, 1'b0, 10'h100, 32'h0,        1'b1, 1'b1, 1'b0, 10'h100, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[4]  = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h12345678, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 10'h010, 32'h0,        1'b1, 1'b1, 1'b0, 10'h010, 32'h0,        1'b0, 32'h12345678, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 10'h020, 32'h1,        1'b1, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 10'h100, 32'h0,        1'b1, 1'b1, 1'b0, 10'h100, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 10'h020, 32'h2,        1'b1, 1'b1, 1'b1, 10'h020, 32'h1,        1'b1, 32'h12345678, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 10'h020, 32'h0,        1'b1, 1'b1, 1'b1, 10'h020, 32'h2,        1'b1, 32'h12345678, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h2,        1'b1};
        tbl[12] = '{1'b1, 1'b0, 10'h020, 32'h0,        1'b1, 1'b1, 1'b0, 10'h020, 32'h0,        1'b0, 32'h2,        1'b1};
        tbl[13] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 32'h2,        1'b1};
        nullv = tbl[2];

        // Reset state, with a read request presented while rst is high
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1; wr = 1'b0; addr = 10'h100;
        @(negedge clk);
        chk("rst_addr_ok", 32'(addr_ok), 32'h0);
        chk("rst_bram_ena", 32'(bram_ena), 32'h0);
        chk("rst_bram_wea", 32'(bram_wea), 32'h0);
        chk("rst_data_ok", 32'(data_ok), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_wb_empty", 32'(wb_empty), 32'h1);
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++)
            cyc(tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i]);

        // Five consecutive writes behind a read miss, then read them back
        cyc(1'b1, 1'b0, 10'h100, 32'h0, 1'b0, nullv);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, 10'(10'h030 + i), 32'hC000_0000 + 32'(i), 1'b0, nullv);
        cyc(1'b1, 1'b0, 10'h100, 32'h0, 1'b0, nullv);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b0, 10'(10'h030 + i), 32'h0, 1'b0, nullv);
        idle(2);

        // Ten writes interleaved with read misses: pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 10'(10'h040 + i), 32'hB000_0000 + 32'(i), 1'b0, nullv);
            cyc(1'b1, 1'b0, 10'h100, 32'h0, 1'b0, nullv);
        end
        idle(2);

        // Write immediately followed by a read of the same address
        cyc(1'b1, 1'b1, 10'h050, 32'h5A5A_5A5A, 1'b0, nullv);
        cyc(1'b1, 1'b0, 10'h050, 32'h0, 1'b0, nullv);
        idle(2);

        // Asynchronous reset with a buffered write held off by a read miss
        cyc(1'b1, 1'b1, 10'h0AA, 32'h5555_5555, 1'b0, nullv);
        req = 1'b1; wr = 1'b0; addr = 10'h100;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_wb_empty", 32'(wb_empty), 32'h1);
        chk("arst_addr_ok", 32'(addr_ok), 32'h0);
        chk("arst_bram_ena", 32'(bram_ena), 32'h0);
        chk("arst_data_ok", 32'(data_ok), 32'h0);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pq.delete();
        for (int i = 0; i < NWORD; i++) ref_mem[i] = bm_ref[i];
        exp_dok = 1'b0; exp_rd = 1'b0; last_rdata = 32'h0;
        idle(3);
        cyc(1'b1, 1'b0, 10'h0AA, 32'h0, 1'b0, nullv);
        idle(1);

        // Randomized traffic over a small address set to provoke hits
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                (r < 8) ? 10'(r) : 10'h100, $urandom, 1'b0, nullv);
        end
        idle(3);

        // BM image must equal all accepted, non-discarded writes in order
        mism = 0;
        for (int i = 0; i < NWORD; i++) if (bm_mem[i] !== bm_ref[i]) mism++;
        chk("bm_image_mismatches", 32'(mism), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
